// File: rtl/tournament_pkg.sv
// Shared types, constants and the saturating-counter helper for the tournament predictor.
package tournament_pkg;

    localparam int unsigned HIST_W_DEF = 10;

    typedef logic [1:0] ctr2_t;

    localparam ctr2_t CTR_SNT = 2'b00;
    localparam ctr2_t CTR_WNT = 2'b01;
    localparam ctr2_t CTR_WT  = 2'b10;
    localparam ctr2_t CTR_ST  = 2'b11;

    typedef enum logic {PHT_INIT, PHT_RUN} pht_state_e;

    function automatic ctr2_t sat_update(ctr2_t ctr, logic taken);
        if (taken) begin
            return (ctr == CTR_ST) ? CTR_ST : ctr + 2'd1;
        end
        return (ctr == CTR_SNT) ? CTR_SNT : ctr - 2'd1;
    endfunction

endpackage

// File: rtl/pht_delay_pipe.sv
// {valid, idx} shift register that remembers which PHT entry each lookup used,
// so the resolve RESOLVE_LAT cycles later trains the same counter.
module pht_delay_pipe #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned IDX_W = 10
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             valid_i,
    input  logic [IDX_W-1:0] idx_i,
    output logic             valid_o,
    output logic [IDX_W-1:0] idx_o
);

    logic [DEPTH-1:0] vld_q;
    logic [IDX_W-1:0] idx_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            vld_q <= '0;
        end else begin
            vld_q[0] <= valid_i;
            for (int unsigned k = 1; k < DEPTH; k++) begin
                vld_q[k] <= vld_q[k-1];
            end
        end
    end

    // Index bits need no reset: they are only consumed when the matching valid is set.
    always_ff @(posedge clk_i) begin
        idx_q[0] <= idx_i;
        for (int unsigned k = 1; k < DEPTH; k++) begin
            idx_q[k] <= idx_q[k-1];
        end
    end

    assign valid_o = vld_q[DEPTH-1];
    assign idx_o   = idx_q[DEPTH-1];

endmodule

// File: rtl/local_prediction_table.sv
// Local PHT of 2-bit saturating counters with init sweep and delayed training.
// Optional write-through forwarding of the same-cycle update: LOCAL_PRED_BYPASS_EN.
module local_prediction_table
    import tournament_pkg::*;
#(
    parameter int unsigned HIST_W      = HIST_W_DEF,
    parameter int unsigned RESOLVE_LAT = 2,
    parameter ctr2_t       INIT_CTR    = CTR_WNT
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [HIST_W-1:0] history_in,
    input  logic              resolve_valid,
    input  logic              resolve_taken,
    output logic              ready,
    output logic              predict_taken,
    output logic              predict_strong
);

    localparam int unsigned DEPTH = 2**HIST_W;

    pht_state_e        state_q, state_d;
    logic [HIST_W-1:0] ptr_q, ptr_d;
    ctr2_t             table_q [DEPTH];

    logic              pipe_valid;
    logic [HIST_W-1:0] pipe_idx;
    logic              sweep_we;
    logic              upd_en;
    ctr2_t             upd_ctr;
    ctr2_t             rd_ctr;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        case (state_q)
            PHT_INIT: begin
                ptr_d = ptr_q + HIST_W'(1);
                if (ptr_q == '1) begin
                    state_d = PHT_RUN;
                end
            end
            PHT_RUN: begin
                state_d = PHT_RUN;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= PHT_INIT;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    assign ready = (state_q == PHT_RUN);

    pht_delay_pipe #(
        .DEPTH (RESOLVE_LAT),
        .IDX_W (HIST_W)
    ) u_pipe (
        .clk_i   (clock),
        .rst_ni  (reset),
        .valid_i (ready),
        .idx_i   (history_in),
        .valid_o (pipe_valid),
        .idx_o   (pipe_idx)
    );

    assign sweep_we = reset && (state_q == PHT_INIT);
    assign upd_en   = reset && ready && resolve_valid && pipe_valid;
    assign upd_ctr  = sat_update(table_q[pipe_idx], resolve_taken);

    always_ff @(posedge clock) begin
        if (sweep_we) begin
            table_q[ptr_q] <= INIT_CTR;
        end else if (upd_en) begin
            table_q[pipe_idx] <= upd_ctr;
        end
    end

    always_comb begin
        rd_ctr = table_q[history_in];
`ifdef LOCAL_PRED_BYPASS_EN
        if (upd_en && (history_in == pipe_idx)) begin
            rd_ctr = upd_ctr;
        end
`endif
        predict_taken  = ready && rd_ctr[1];
        predict_strong = ready && ((rd_ctr == CTR_SNT) || (rd_ctr == CTR_ST));
    end

endmodule

// File: tb/tb_local_prediction_table.sv
// Scoreboard bench for local_prediction_table: a behavioural model queues the
// expected outputs per cycle and a negedge monitor compares them.
module tb_local_prediction_table;

    localparam int DEPTH = 1024;
    localparam int LAT   = 2;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [9:0] history_in = '0;
    logic       resolve_valid = 1'b0;
    logic       resolve_taken = 1'b0;
    logic       ready, predict_taken, predict_strong;

    local_prediction_table #(
        .HIST_W      (10),
        .RESOLVE_LAT (LAT),
        .INIT_CTR    (2'b01)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .history_in     (history_in),
        .resolve_valid  (resolve_valid),
        .resolve_taken  (resolve_taken),
        .ready          (ready),
        .predict_taken  (predict_taken),
        .predict_strong (predict_strong)
    );

    always #5 clock = ~clock;

    typedef struct {
        bit rdy;
        bit tk;
        bit st;
        int cyc;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   total = 0;
    int   bad   = 0;

    // Reference model: counters as plain integers, lookups remembered in a queue.
    int   model [DEPTH];
    int   sweep_cnt = 0;
    bit   lk_v[$];
    int   lk_i[$];
    int   cyc = 0;
    bit   bypass = 1'b0;

    function automatic int sat(int c, bit t);
        if (t) return (c + 1 > 3) ? 3 : c + 1;
        return (c - 1 < 0) ? 0 : c - 1;
    endfunction

    task automatic clear_lookups();
        lk_v.delete();
        lk_i.delete();
        for (int k = 0; k < LAT; k++) begin
            lk_v.push_back(1'b0);
            lk_i.push_back(0);
        end
    endtask

    task automatic step(input bit r, input int h, input bit v, input bit t);
        exp_t e;
        bit   rdy, upd;
        int   c, newc, fi;
        @(posedge clock);
        #1;
        reset         = r;
        history_in    = 10'(h);
        resolve_valid = v;
        resolve_taken = t;

        rdy  = (sweep_cnt >= DEPTH);
        fi   = lk_i[0];
        upd  = r && rdy && v && lk_v[0];
        newc = upd ? sat(model[fi], t) : 0;
        c    = (bypass && upd && (h == fi)) ? newc : model[h];
        e.rdy = rdy;
        e.tk  = rdy && (c >= 2);
        e.st  = rdy && (c == 0 || c == 3);
        e.cyc = cyc;
        exp_q.push_back(e);
        cyc++;

        if (!r) begin
            sweep_cnt = 0;
            clear_lookups();
        end else begin
            if (upd) model[fi] = newc;
            if (sweep_cnt < DEPTH) begin
                sweep_cnt++;
                if (sweep_cnt == DEPTH) begin
                    for (int k = 0; k < DEPTH; k++) model[k] = 1;
                end
            end
            lk_v.push_back(rdy);
            lk_i.push_back(h);
            void'(lk_v.pop_front());
            void'(lk_i.pop_front());
        end
    endtask

    always @(negedge clock) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            total++;
            if ({ready, predict_taken, predict_strong} !== {mon_e.rdy, mon_e.tk, mon_e.st}) begin
                bad++;
                $display("FAIL outputs cyc=%0d got ready/taken/strong=%b%b%b expected %b%b%b",
                         mon_e.cyc, ready, predict_taken, predict_strong,
                         mon_e.rdy, mon_e.tk, mon_e.st);
            end
        end
    end

    initial begin
`ifdef LOCAL_PRED_BYPASS_EN
        bypass = 1'b1;
`endif
        for (int k = 0; k < DEPTH; k++) model[k] = 1;
        clear_lookups();
        repeat (2) @(posedge clock);

        // Reset held three cycles, then the full sweep with ignored resolves.
        repeat (3) step(0, $urandom_range(0, 1023), 1, 1);
        repeat (DEPTH) step(1, $urandom_range(0, 1023), $urandom_range(0, 1), $urandom_range(0, 1));
        repeat (8) step(1, $urandom_range(0, 1023), 0, 0);

        // Same-cycle update and lookup of entry 0x2A (01 -> 10).
        step(1, 'h2A, 0, 0);
        step(1, 'h11, 0, 0);
        step(1, 'h2A, 1, 1);
        step(1, 'h2A, 0, 0);

        // Training, saturation, then decrement to 00.
        repeat (2) step(1, 'h155, 0, 0);
        repeat (8) step(1, 'h155, 1, 1);
        repeat (4) step(1, 'h155, 1, 0);
        repeat (3) step(1, 'h155, 0, 0);

        // Delay alignment: only the lookup of 3 is trained.
        step(1, 3, 0, 0);
        step(1, 7, 0, 0);
        step(1, 9, 1, 1);
        step(1, 'h100, 0, 0);
        step(1, 'h101, 0, 0);
        step(1, 3, 0, 0);
        step(1, 7, 0, 0);
        step(1, 9, 0, 0);

        // Drive entry 3 to 11, then reset in RUN and again mid-sweep.
        repeat (6) step(1, 3, 1, 1);
        step(0, 3, 1, 1);
        repeat (500) step(1, $urandom_range(0, 1023), $urandom_range(0, 1), $urandom_range(0, 1));
        step(0, 3, 1, 1);
        step(1, 3, 1, 1);
        repeat (DEPTH - 1) step(1, $urandom_range(0, 1023), $urandom_range(0, 1), $urandom_range(0, 1));
        step(1, 3, 0, 0);
        step(1, 7, 0, 0);
        step(1, 3, 0, 0);

        // Random traffic over a small index range for collisions and forwarding hits.
        repeat (3000) step(1, $urandom_range(0, 15), $urandom_range(0, 1), $urandom_range(0, 1));

        @(negedge clock);
        #1;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain got %0d pending expected 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
